// File: rtl/neuron_timestep_controller_pkg.sv
// Shared definitions for the neuron timestep controller slice: FP32 field
// layout, controller state encoding and the LIF threshold that the
// potential_adder also uses.
package neuron_timestep_controller_pkg;

  // FP32 field positions
  localparam int FP_SIGN_BIT = 31;
  localparam int FP_EXP_MSB  = 30;
  localparam int FP_EXP_LSB  = 23;
  localparam int FP_MAN_MSB  = 22;
  localparam int FP_MAN_LSB  = 0;

  typedef logic [FP_EXP_MSB-FP_EXP_LSB:0] fp_exp_t;

  // All-ones exponent marks Inf/NaN
  localparam fp_exp_t EXP_INF = 8'hFF;

  // Spike threshold (40.0), shared with the adder
  localparam logic [31:0] THRESHOLD_LIF = 32'h4220_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ_W,
    ST_CLEAR,
    ST_SET,
    ST_EVAL,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  // Extract the biased exponent field of an FP32 word
  function automatic fp_exp_t fp_exp(input logic [31:0] x);
    return x[FP_EXP_MSB:FP_EXP_LSB];
  endfunction

endpackage

// File: rtl/neuron_timestep_controller_decay.sv
// Exponent-shift decay of an FP32 value: divides by 2**DECAY_SHIFT by
// lowering the exponent. Inf/NaN pass through; values that would drop to
// or below the denormal range flush to +0.
module fp_exp_decay
  import neuron_timestep_controller_pkg::*;
#(
  parameter int DECAY_SHIFT = 1
) (
  input  logic [31:0] i_x,
  output logic [31:0] o_y
);

  localparam fp_exp_t SHIFT = fp_exp_t'(DECAY_SHIFT);

  logic [7:0] w_exp;

  assign w_exp = fp_exp(i_x);

  // Select pass-through, flush-to-zero or reduced exponent
  always_comb begin
    o_y = i_x;
    if (DECAY_SHIFT == 0 || w_exp == EXP_INF) begin
      o_y = i_x;
    end else if (w_exp <= SHIFT) begin
      o_y = '0;
    end else begin
      o_y = {i_x[FP_SIGN_BIT], w_exp - SHIFT, i_x[FP_MAN_MSB:FP_MAN_LSB]};
    end
  end

endmodule

// File: rtl/neuron_timestep_controller.sv
// Timestep sequencer for a small neuron slice. For every neuron it fetches a
// weight, presents weight and decayed potential to the shared
// potential_adder, waits for the combinational FP path to settle and stores
// the result and spike flag back.
module neuron_timestep_controller
  import neuron_timestep_controller_pkg::*;
#(
  parameter int NUM_NEURONS   = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int DECAY_SHIFT   = 1
) (
  input  logic                           CLK_Ctrl,
  input  logic                           rst_n_ctrl,
  input  logic                           start,
  input  logic                           soft_clear,
  input  logic                           weight_valid,
  output logic                           weight_ready,
  input  logic [31:0]                    weight_in,
  output logic [$clog2(NUM_NEURONS)-1:0] cur_neuron,
  output logic                           set_adder,
  output logic                           clear_adder,
  output logic [31:0]                    input_weight,
  output logic [31:0]                    decayed_potential,
  input  logic [31:0]                    final_potential,
  input  logic                           spike,
  output logic [NUM_NEURONS-1:0]         spike_vec,
  input  logic [$clog2(NUM_NEURONS)-1:0] rd_sel,
  output logic [31:0]                    rd_potential,
  output logic                           busy,
  output logic                           done
);

  localparam int IDX_W = $clog2(NUM_NEURONS);
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_NEURONS - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t r_state;
  state_t w_next_state;

  logic [IDX_W-1:0]       r_cur_neuron;
  logic [CNT_W-1:0]       r_settle_cnt;
  logic [31:0]            r_input_weight;
  logic [31:0]            r_decayed;
  logic [31:0]            r_pot [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] r_shadow;
  logic [NUM_NEURONS-1:0] r_spike_vec;
  logic                   r_weight_ready;
  logic                   r_set_adder;
  logic                   r_clear_adder;
  logic                   r_busy;
  logic                   r_done;

  logic                   w_handshake;
  logic                   w_start_acc;
  logic                   w_soft_clear_en;
  logic                   w_last;
  logic                   w_settled;
  logic [31:0]            w_pot_cur;
  logic [31:0]            w_decayed;
  logic [NUM_NEURONS-1:0] w_shadow_next;

  assign w_handshake     = (r_state == ST_REQ_W) && weight_valid && r_weight_ready;
  assign w_soft_clear_en = (r_state == ST_IDLE) && soft_clear;
  assign w_start_acc     = (r_state == ST_IDLE) && start && !soft_clear;
  assign w_last          = (r_cur_neuron == LAST_IDX);
  assign w_settled       = (r_settle_cnt == SETTLE_LAST);
  assign w_pot_cur       = r_pot[r_cur_neuron];

  fp_exp_decay #(
    .DECAY_SHIFT(DECAY_SHIFT)
  ) u_decay (
    .i_x(w_pot_cur),
    .o_y(w_decayed)
  );

  // Spike shadow with the current neuron's adder flag merged in
  always_comb begin
    w_shadow_next               = r_shadow;
    w_shadow_next[r_cur_neuron] = spike;
  end

  // State register
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge CLK_Ctrl or negedge rst_n_ctrl) begin
    if (!rst_n_ctrl) r_state <= ST_IDLE;
    else             r_state <= w_next_state;
  end

  // Next-state decode
  // NOTE: the default assignment first keeps every path assigned, so no
  // latch is inferred for w_next_state.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:    if (w_start_acc) w_next_state = ST_REQ_W;
      ST_REQ_W:   if (w_handshake) w_next_state = ST_CLEAR;
      ST_CLEAR:   w_next_state = ST_SET;
      ST_SET:     w_next_state = ST_EVAL;
      ST_EVAL:    if (w_settled) w_next_state = ST_CAPTURE;
      ST_CAPTURE: w_next_state = w_last ? ST_DONE : ST_REQ_W;
      ST_DONE:    w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // Control outputs registered from the next state so they align with it
  always_ff @(posedge CLK_Ctrl or negedge rst_n_ctrl) begin
    if (!rst_n_ctrl) begin
      r_weight_ready <= 1'b0;
      r_clear_adder  <= 1'b0;
      r_set_adder    <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_weight_ready <= (w_next_state == ST_REQ_W);
      r_clear_adder  <= (w_next_state == ST_CLEAR);
      r_set_adder    <= (w_next_state == ST_SET);
      r_busy         <= !(w_next_state inside {ST_IDLE, ST_DONE});
      r_done         <= (w_next_state == ST_DONE);
    end
  end

  // Neuron index, settle counter and adder operands
  always_ff @(posedge CLK_Ctrl or negedge rst_n_ctrl) begin
    if (!rst_n_ctrl) begin
      r_cur_neuron   <= '0;
      r_settle_cnt   <= '0;
      r_input_weight <= '0;
      r_decayed      <= '0;
    end else begin
      if (w_start_acc) begin
        r_cur_neuron <= '0;
      end else if (r_state == ST_CAPTURE && !w_last) begin
        r_cur_neuron <= r_cur_neuron + 1'b1;
      end

      if (r_state == ST_EVAL) r_settle_cnt <= r_settle_cnt + 1'b1;
      else                    r_settle_cnt <= '0;

      // Operands change only at the weight handshake, so they stay stable
      // from CLEAR through CAPTURE and across weight stalls.
      if (w_handshake) begin
        r_input_weight <= weight_in;
        r_decayed      <= w_decayed;
      end
    end
  end

  // Potential store, spike shadow and published spike vector
  // NOTE: the potential store is a handful of flops that must read as zero
  // after reset, so it is reset explicitly rather than left as RAM.
  always_ff @(posedge CLK_Ctrl or negedge rst_n_ctrl) begin
    if (!rst_n_ctrl) begin
      for (int i = 0; i < NUM_NEURONS; i++) r_pot[i] <= '0;
      r_shadow    <= '0;
      r_spike_vec <= '0;
    end else begin
      if (w_soft_clear_en) begin
        for (int i = 0; i < NUM_NEURONS; i++) r_pot[i] <= '0;
        r_shadow    <= '0;
        r_spike_vec <= '0;
      end else if (w_start_acc) begin
        r_shadow <= '0;
      end else if (r_state == ST_CAPTURE) begin
        r_pot[r_cur_neuron] <= final_potential;
        r_shadow            <= w_shadow_next;
        if (w_last) r_spike_vec <= w_shadow_next;
      end
    end
  end

  assign weight_ready      = r_weight_ready;
  assign set_adder         = r_set_adder;
  assign clear_adder       = r_clear_adder;
  assign cur_neuron        = r_cur_neuron;
  assign input_weight      = r_input_weight;
  assign decayed_potential = r_decayed;
  assign spike_vec         = r_spike_vec;
  assign busy              = r_busy;
  assign done              = r_done;
  assign rd_potential      = r_pot[rd_sel];

endmodule

// File: tb/tb_neuron_timestep_controller.sv
// Bench for neuron_timestep_controller: a behavioural FP adder stands in for
// potential_adder, a responsive weight source drives the handshake, and the
// expected operands per neuron are queued when each weight is offered.
module tb_neuron_timestep_controller;
  import neuron_timestep_controller_pkg::*;

  localparam int N = 4;
  localparam int DECAY = 1;

  logic        CLK_Ctrl = 1'b0;
  logic        rst_n_ctrl;
  logic        start, soft_clear, weight_valid;
  logic        weight_ready, set_adder, clear_adder, spike, busy, done;
  logic [31:0] weight_in, input_weight, decayed_potential, final_potential, rd_potential;
  logic [1:0]  cur_neuron, rd_sel;
  logic [3:0]  spike_vec;

  always #5 CLK_Ctrl = ~CLK_Ctrl;

  neuron_timestep_controller #(
    .NUM_NEURONS(N), .SETTLE_CYCLES(4), .DECAY_SHIFT(DECAY)
  ) dut (
    .CLK_Ctrl(CLK_Ctrl), .rst_n_ctrl(rst_n_ctrl), .start(start),
    .soft_clear(soft_clear), .weight_valid(weight_valid),
    .weight_ready(weight_ready), .weight_in(weight_in),
    .cur_neuron(cur_neuron), .set_adder(set_adder),
    .clear_adder(clear_adder), .input_weight(input_weight),
    .decayed_potential(decayed_potential),
    .final_potential(final_potential), .spike(spike),
    .spike_vec(spike_vec), .rd_sel(rd_sel), .rd_potential(rd_potential),
    .busy(busy), .done(done)
  );

  // ---------------- reference arithmetic ----------------
  function automatic real fp_to_real(input logic [31:0] x);
    real r;
    int  e;
    e = int'(x[30:23]);
    if (e == 0) return 0.0;
    r = 1.0 + real'(x[22:0]) / 8388608.0;
    for (int i = 0; i < e - 127; i++) r = r * 2.0;
    for (int i = 0; i < 127 - e; i++) r = r / 2.0;
    return x[31] ? -r : r;
  endfunction

  function automatic logic [31:0] real_to_fp(input real r);
    logic [63:0] b;
    int          fe;
    if (r == 0.0) return 32'h0;
    b  = $realtobits(r);
    fe = int'(b[62:52]) - 1023 + 127;
    if (fe <= 0)   return 32'h0;
    if (fe >= 255) return {b[63], 8'hFF, 23'h0};
    return {b[63], fe[7:0], b[51:29]};
  endfunction

  // LIF step: spike and reset to zero when the sum reaches threshold
  function automatic logic [32:0] adder_fn(input logic [31:0] w, input logic [31:0] p);
    real s;
    s = fp_to_real(w) + fp_to_real(p);
    if (s >= fp_to_real(THRESHOLD_LIF)) return {1'b1, 32'h0};
    return {1'b0, real_to_fp(s)};
  endfunction

  function automatic logic [31:0] model_decay(input logic [31:0] x);
    int e;
    e = int'(x[30:23]);
    if (DECAY == 0 || e == 255) return x;
    if (e - DECAY < 1) return 32'h0;
    return {x[31], 8'(e - DECAY), x[22:0]};
  endfunction

  // ---------------- adder stand-in ----------------
  bit          ovr_en = 1'b0;
  logic [31:0] ovr_val [N];
  logic [32:0] w_add;

  assign w_add           = adder_fn(input_weight, decayed_potential);
  assign final_potential = ovr_en ? ovr_val[cur_neuron] : w_add[31:0];
  assign spike           = ovr_en ? 1'b0 : w_add[32];

  // ---------------- scoreboard / model state ----------------
  typedef struct {
    int          idx;
    logic [31:0] w;
    logic [31:0] dec;
  } sb_t;

  sb_t         sb_q[$];
  logic [31:0] ts_w [N];
  logic [31:0] m_pot [N];
  logic [31:0] obs_dec [N];
  logic [3:0]  m_shadow, m_spike_vec;
  int          m_idx;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One negedge of weight-source service: pop/compare on the CLEAR strobe,
  // offer the next weight when requested unless holding it back.
  task automatic service(input bit hold_valid);
    sb_t         e;
    logic [31:0] dec, res;
    logic        sp;
    logic [32:0] a;
    if (clear_adder) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("n%0d_idx", e.idx), 32'(cur_neuron), 32'(e.idx));
        check($sformatf("n%0d_weight", e.idx), input_weight, e.w);
        check($sformatf("n%0d_decayed", e.idx), decayed_potential, e.dec);
        obs_dec[e.idx] = decayed_potential;
      end
    end
    if (weight_ready && !hold_valid && m_idx < N) begin
      weight_valid = 1'b1;
      weight_in    = ts_w[m_idx];
      dec          = model_decay(m_pot[m_idx]);
      if (ovr_en) begin
        res = ovr_val[m_idx];
        sp  = 1'b0;
      end else begin
        a   = adder_fn(ts_w[m_idx], dec);
        res = a[31:0];
        sp  = a[32];
      end
      sb_q.push_back('{idx: m_idx, w: ts_w[m_idx], dec: dec});
      m_pot[m_idx]    = res;
      m_shadow[m_idx] = sp;
      m_idx++;
    end else begin
      weight_valid = 1'b0;
    end
  endtask

  task automatic check_pots(input string tag);
    for (int i = 0; i < N; i++) begin
      rd_sel = 2'(i);
      #1;
      check($sformatf("%s_pot%0d", tag, i), rd_potential, m_pot[i]);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ctl"}, {27'd0, weight_ready, set_adder, clear_adder, busy, done}, 32'd0);
    check({tag, "_spike_vec"}, 32'(spike_vec), 32'd0);
    check({tag, "_in_w"}, input_weight, 32'd0);
    check({tag, "_dec"}, decayed_potential, 32'd0);
    check({tag, "_cur"}, 32'(cur_neuron), 32'd0);
    for (int i = 0; i < N; i++) begin
      rd_sel = 2'(i);
      #1;
      check($sformatf("%s_pot%0d", tag, i), rd_potential, 32'd0);
    end
  endtask

  // Run one timestep from a negedge; returns at the negedge after done.
  task automatic run_ts(input string tag, input int stall_n, input int stall_cyc,
                        input bit poke, input int exp_cycles);
    int cycles;
    int stall_left;
    bit seen_done;
    bit hold;
    stall_left = stall_cyc;
    seen_done  = 1'b0;
    m_idx      = 0;
    m_shadow   = '0;
    start      = 1'b1;
    @(negedge CLK_Ctrl);
    start  = 1'b0;
    cycles = 1;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    while (!seen_done && cycles < 300) begin
      if (done) begin
        seen_done = 1'b1;
      end else begin
        hold  = weight_ready && (m_idx == stall_n) && (stall_left > 0);
        start = poke && hold && (stall_left == 5);
        if (hold) begin
          check({tag, "_stall_ctl"}, {29'd0, weight_ready, set_adder, clear_adder}, 32'd4);
          if (stall_left == 1) check({tag, "_stall_spike_vec"}, 32'(spike_vec), 32'(m_spike_vec));
          stall_left--;
        end
        service(hold);
        @(negedge CLK_Ctrl);
        cycles++;
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(seen_done), 32'd1);
    check({tag, "_latency"}, 32'(cycles), 32'(exp_cycles));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    m_spike_vec = m_shadow;
    check({tag, "_spike_vec"}, 32'(spike_vec), 32'(m_spike_vec));
    check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
    @(negedge CLK_Ctrl);
    check({tag, "_done_pulse"}, {30'd0, done, busy}, 32'd0);
    check_pots(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit hit;
    int done_cnt;
    int busy_cnt;
    rst_n_ctrl   = 1'b0;
    start        = 1'b0;
    soft_clear   = 1'b0;
    weight_valid = 1'b0;
    weight_in    = '0;
    rd_sel       = '0;
    m_spike_vec  = '0;
    m_shadow     = '0;
    m_idx        = 0;
    for (int i = 0; i < N; i++) begin
      m_pot[i]   = '0;
      ovr_val[i] = '0;
      obs_dec[i] = '0;
    end

    // Reset state
    #12;
    check_idle("reset");
    @(negedge CLK_Ctrl);
    rst_n_ctrl = 1'b1;
    @(negedge CLK_Ctrl);

    // Timestep 1: all weights 20.0 from zero potentials
    for (int i = 0; i < N; i++) ts_w[i] = 32'h41A0_0000;
    run_ts("ts1", -1, 0, 1'b0, 33);
    for (int i = 0; i < N; i++) check($sformatf("ts1_pot_const%0d", i), m_pot[i] == 32'h41A0_0000 ? rd_potential : 32'hX, 32'h41A0_0000);

    // Timestep 2: same weights, stored 20.0 decays to 10.0
    run_ts("ts2", -1, 0, 1'b0, 33);
    for (int i = 0; i < N; i++) check($sformatf("ts2_dec_const%0d", i), obs_dec[i], 32'h4120_0000);

    // Timestep 3: only neuron 2 crosses threshold
    for (int i = 0; i < N; i++) ts_w[i] = 32'h0;
    ts_w[2] = 32'h4234_0000;
    run_ts("ts3", -1, 0, 1'b0, 33);
    check("ts3_spike_const", 32'(spike_vec), 32'h4);

    // Timestep 4: neuron 1 weight withheld 10 cycles, start poked while busy
    for (int i = 0; i < N; i++) ts_w[i] = 32'h0;
    run_ts("ts4", 1, 10, 1'b1, 43);
    repeat (3) @(negedge CLK_Ctrl);
    check("ts4_no_restart", {30'd0, busy, weight_ready}, 32'd0);

    // Timestep 5: adder forced to plant boundary potentials
    ovr_en     = 1'b1;
    ovr_val[0] = 32'h0080_0000;
    ovr_val[1] = 32'h7F80_0000;
    ovr_val[2] = 32'hC1A0_0000;
    ovr_val[3] = 32'h3F80_0000;
    run_ts("ts5", -1, 0, 1'b0, 33);

    // Timestep 6: observe decay of those boundary potentials
    for (int i = 0; i < N; i++) ovr_val[i] = 32'h0;
    run_ts("ts6", -1, 0, 1'b0, 33);
    check("decay_exp01", obs_dec[0], 32'h0000_0000);
    check("decay_inf", obs_dec[1], 32'h7F80_0000);
    check("decay_neg", obs_dec[2], 32'hC120_0000);
    check("decay_one", obs_dec[3], 32'h3F00_0000);
    ovr_en = 1'b0;

    // Reset asserted during EVAL of neuron 3
    for (int i = 0; i < N; i++) ts_w[i] = 32'h41A0_0000;
    m_idx    = 0;
    m_shadow = '0;
    hit      = 1'b0;
    start    = 1'b1;
    @(negedge CLK_Ctrl);
    start = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      if (set_adder && cur_neuron == 2'd3) hit = 1'b1;
      service(1'b0);
      @(negedge CLK_Ctrl);
    end
    check("rst_reached_eval3", 32'(hit), 32'd1);
    rst_n_ctrl   = 1'b0;
    weight_valid = 1'b0;
    #1;
    check_idle("rst_mid");
    sb_q.delete();
    for (int i = 0; i < N; i++) m_pot[i] = '0;
    m_spike_vec = '0;
    done_cnt    = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK_Ctrl);
      if (c == 2) rst_n_ctrl = 1'b1;
      if (done) done_cnt++;
    end
    check("rst_no_done", 32'(done_cnt), 32'd0);

    // Soft clear together with start: clear wins, nothing starts
    for (int i = 0; i < N; i++) ts_w[i] = 32'h41A0_0000;
    ts_w[0] = 32'h4234_0000;
    run_ts("ts7", -1, 0, 1'b0, 33);
    check("ts7_spike_const", 32'(spike_vec), 32'h1);
    soft_clear = 1'b1;
    start      = 1'b1;
    @(negedge CLK_Ctrl);
    soft_clear = 1'b0;
    start      = 1'b0;
    busy_cnt   = 0;
    for (int c = 0; c < 10; c++) begin
      if (busy || weight_ready) busy_cnt++;
      @(negedge CLK_Ctrl);
    end
    check("sclr_no_start", 32'(busy_cnt), 32'd0);
    for (int i = 0; i < N; i++) m_pot[i] = '0;
    check_pots("sclr");
    check("sclr_spike_vec", 32'(spike_vec), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
